cmp_cond_unit: RTL and testbench

- Consumer end of the ALU comparator interface.
- Accepts the 4-bit comparator flag word {1'b0, a_gt_b, b_gt_a, a_eq_b} with a condition code over a valid/ready handshake.
- Checks the flag word for legality and evaluates the selected branch condition.
- Returns a registered result over a second valid/ready handshake, and keeps a sticky error flag and a saturating count of true conditions for the ALU status path.

---
 rtl/cmp_cond_unit_pkg.sv | 33 +++
 rtl/cmp_cond_unit_eval.sv | 42 ++++
 rtl/cmp_cond_unit.sv | 109 ++++++++++
 tb/tb_cmp_cond_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cmp_cond_unit_pkg.sv
// Shared ALU comparator definitions: condition codes, flag bit positions,
// legal flag words and the output FSM state type.
package cmp_cond_unit_pkg;

  localparam logic [2:0] COND_EQ     = 3'd0;
  localparam logic [2:0] COND_NE     = 3'd1;
  localparam logic [2:0] COND_GT     = 3'd2;
  localparam logic [2:0] COND_LT     = 3'd3;
  localparam logic [2:0] COND_GE     = 3'd4;
  localparam logic [2:0] COND_LE     = 3'd5;
  localparam logic [2:0] COND_ALWAYS = 3'd6;
  localparam logic [2:0] COND_NEVER  = 3'd7;

  localparam int FLAG_EQ   = 0;
  localparam int FLAG_LT   = 1;
  localparam int FLAG_GT   = 2;
  localparam int FLAG_RSVD = 3;

  localparam logic [3:0] FLAGS_EQ = 4'b0001;
  localparam logic [3:0] FLAGS_LT = 4'b0010;
  localparam logic [3:0] FLAGS_GT = 4'b0100;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // A comparator word is legal only when exactly one relation bit is set.
  function automatic logic flags_legal(input logic [3:0] flags);
    return (flags == FLAGS_EQ) || (flags == FLAGS_LT) || (flags == FLAGS_GT);
  endfunction

endpackage

// File: rtl/cmp_cond_unit_eval.sv
// Combinational branch-condition evaluator: (flags, cond) -> (true, err).
// Shared with the branch unit, so it carries no state.
module cmp_cond_eval
  import cmp_cond_unit_pkg::*;
(
  input  logic [3:0] i_flags,
  input  logic [2:0] i_cond,
  output logic       o_true,
  output logic       o_err
);

  logic w_legal;
  logic w_eq;
  logic w_lt;
  logic w_gt;
  logic w_raw;

  assign w_legal = flags_legal(i_flags);
  assign w_eq    = i_flags[FLAG_EQ];
  assign w_lt    = i_flags[FLAG_LT];
  assign w_gt    = i_flags[FLAG_GT];

  always_comb begin
    w_raw = 1'b0;
    case (i_cond)
      COND_EQ:     w_raw = w_eq;
      COND_NE:     w_raw = ~w_eq;
      COND_GT:     w_raw = w_gt;
      COND_LT:     w_raw = w_lt;
      COND_GE:     w_raw = w_gt | w_eq;
      COND_LE:     w_raw = w_lt | w_eq;
      COND_ALWAYS: w_raw = 1'b1;
      COND_NEVER:  w_raw = 1'b0;
      default:     w_raw = 1'b0;
    endcase
  end

  // An illegal word forces false even for ALWAYS.
  assign o_true = w_legal & w_raw;
  assign o_err  = ~w_legal;

endmodule

// File: rtl/cmp_cond_unit.sv
// Consumer end of the ALU comparator interface: one-deep registered result
// stage with sticky error flag and saturating count of true handoffs.
module cmp_cond_unit
  import cmp_cond_unit_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_flags,
  input  logic [2:0]       in_cond,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_true,
  output logic             out_err,
  output logic [3:0]       out_flags,
  output logic             err_sticky,
  input  logic             err_clr,
  output logic [CNT_W-1:0] match_cnt,
  input  logic             cnt_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_out_true;
  logic             r_out_err;
  logic [3:0]       r_out_flags;
  logic             r_err_sticky;
  logic [CNT_W-1:0] r_match_cnt;

  logic w_eval_true;
  logic w_eval_err;
  logic w_in_ready;
  logic w_out_valid;
  logic w_capture;
  logic w_handoff;

  cmp_cond_eval u_eval (
    .i_flags (in_flags),
    .i_cond  (in_cond),
    .o_true  (w_eval_true),
    .o_err   (w_eval_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_next;
  end

  // Ready is gated by rst_n so nothing is accepted while reset is held.
  always_comb begin
    w_state_next = r_state;
    w_out_valid  = 1'b0;
    w_in_ready   = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        w_in_ready = rst_n;
        if (in_valid) w_state_next = ST_FULL;
      end
      ST_FULL: begin
        w_out_valid = 1'b1;
        w_in_ready  = rst_n & out_ready;
        if (out_ready && !in_valid) w_state_next = ST_EMPTY;
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  assign w_capture = in_valid & w_in_ready;
  assign w_handoff = w_out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_true  <= 1'b0;
      r_out_err   <= 1'b0;
      r_out_flags <= 4'b0000;
    end else if (w_capture) begin
      r_out_true  <= w_eval_true;
      r_out_err   <= w_eval_err;
      r_out_flags <= in_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                      r_err_sticky <= 1'b0;
    else if (w_capture && w_eval_err) r_err_sticky <= 1'b1;
    else if (err_clr)                r_err_sticky <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr)
      r_match_cnt <= '0;
    else if (w_handoff && r_out_true && (r_match_cnt != CNT_MAX))
      r_match_cnt <= r_match_cnt + 1'b1;
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = w_out_valid;
  assign out_true   = r_out_true;
  assign out_err    = r_out_err;
  assign out_flags  = r_out_flags;
  assign err_sticky = r_err_sticky;
  assign match_cnt  = r_match_cnt;

endmodule

// File: tb/tb_cmp_cond_unit.sv
// Randomised and directed bench for cmp_cond_unit; two instances (CNT_W=8 and
// CNT_W=2) share stimulus and are compared to a transaction-level model.
module tb_cmp_cond_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_flags = 4'b0;
  logic [2:0] in_cond = 3'b0;
  logic       out_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic       cnt_clr = 1'b0;

  logic       in_ready, out_valid, out_true, out_err, err_sticky;
  logic [3:0] out_flags;
  logic [7:0] match_cnt;
  logic       in_ready2, out_valid2, out_true2, out_err2, err_sticky2;
  logic [3:0] out_flags2;
  logic [1:0] match_cnt2;

  int checks = 0;
  int errors = 0;

  // Model: the held result (if any) plus status registers.
  logic       m_valid, m_true, m_err, m_sticky;
  logic [3:0] m_flags;
  int         m_cnt8, m_cnt2;

  always #5 clk = ~clk;

  cmp_cond_unit #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_flags(in_flags), .in_cond(in_cond), .out_valid(out_valid),
    .out_ready(out_ready), .out_true(out_true), .out_err(out_err),
    .out_flags(out_flags), .err_sticky(err_sticky), .err_clr(err_clr),
    .match_cnt(match_cnt), .cnt_clr(cnt_clr)
  );

  cmp_cond_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_flags(in_flags), .in_cond(in_cond), .out_valid(out_valid2),
    .out_ready(out_ready), .out_true(out_true2), .out_err(out_err2),
    .out_flags(out_flags2), .err_sticky(err_sticky2), .err_clr(err_clr),
    .match_cnt(match_cnt2), .cnt_clr(cnt_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  // Branch semantics from the comparison meaning, not from the flag encoding.
  function automatic void ref_eval(input logic [3:0] f, input logic [2:0] c,
                                   output logic t, output logic e);
    int rel;  // -1: A<B, 0: A==B, 1: A>B
    e = !(f == 4'b0001 || f == 4'b0010 || f == 4'b0100);
    rel = (f == 4'b0100) ? 1 : (f == 4'b0010) ? -1 : 0;
    case (c)
      3'd0: t = (rel == 0);
      3'd1: t = (rel != 0);
      3'd2: t = (rel > 0);
      3'd3: t = (rel < 0);
      3'd4: t = (rel >= 0);
      3'd5: t = (rel <= 0);
      3'd6: t = 1'b1;
      default: t = 1'b0;
    endcase
    if (e) t = 1'b0;
  endfunction

  task automatic check_outputs();
    check("out_valid", out_valid, m_valid);
    check("out_true", out_true, m_true);
    check("out_err", out_err, m_err);
    check("out_flags", out_flags, m_flags);
    check("err_sticky", err_sticky, m_sticky);
    check("match_cnt", match_cnt, m_cnt8);
    check("out_valid_w2", out_valid2, m_valid);
    check("out_true_w2", out_true2, m_true);
    check("out_err_w2", out_err2, m_err);
    check("out_flags_w2", out_flags2, m_flags);
    check("err_sticky_w2", err_sticky2, m_sticky);
    check("match_cnt_w2", match_cnt2, m_cnt2);
  endtask

  // One clock: drive inputs, check ready, advance model, check registered outputs.
  task automatic cycle(input logic rn, input logic iv, input logic [3:0] fl,
                       input logic [2:0] cd, input logic ordy,
                       input logic eclr, input logic cclr);
    logic exp_ready, handoff, cap, et, ee;
    rst_n = rn; in_valid = iv; in_flags = fl; in_cond = cd;
    out_ready = ordy; err_clr = eclr; cnt_clr = cclr;
    #1;
    exp_ready = rn && (!m_valid || ordy);
    check("in_ready", in_ready, exp_ready);
    check("in_ready_w2", in_ready2, exp_ready);
    handoff = m_valid && ordy;
    cap = iv && exp_ready;
    ref_eval(fl, cd, et, ee);
    @(posedge clk);
    if (!rn) begin
      m_valid = 0; m_true = 0; m_err = 0; m_flags = 0; m_sticky = 0;
      m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      if (cclr) begin
        m_cnt8 = 0; m_cnt2 = 0;
      end else if (handoff && m_true) begin
        m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
        m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
      end
      if (cap && ee) m_sticky = 1;
      else if (eclr) m_sticky = 0;
      if (cap) begin
        m_valid = 1; m_true = et; m_err = ee; m_flags = fl;
      end else if (handoff) begin
        m_valid = 0;
      end
    end
    #1;
    check_outputs();
  endtask

  initial begin
    logic [3:0] fl;
    m_valid = 0; m_true = 0; m_err = 0; m_flags = 0; m_sticky = 0;
    m_cnt8 = 0; m_cnt2 = 0;

    // Reset then idle.
    cycle(0, 0, 4'b0000, 3'd0, 0, 0, 0);
    cycle(0, 1, 4'b0100, 3'd6, 1, 0, 0);
    cycle(1, 0, 4'b0000, 3'd0, 1, 0, 0);

    // Legal codes back-to-back: GT with GT/GE/NE, then EQ with LT.
    cycle(1, 1, 4'b0100, 3'd2, 1, 0, 0);
    cycle(1, 1, 4'b0100, 3'd4, 1, 0, 0);
    cycle(1, 1, 4'b0100, 3'd1, 1, 0, 0);
    cycle(1, 1, 4'b0001, 3'd3, 1, 0, 0);
    cycle(1, 0, 4'b0000, 3'd0, 1, 0, 0);
    check("cnt_after_four", match_cnt, 3);

    // Illegal words with ALWAYS; err_clr coincides with the last capture.
    cycle(1, 1, 4'b1000, 3'd6, 1, 0, 0);
    cycle(1, 1, 4'b0110, 3'd6, 1, 0, 0);
    cycle(1, 1, 4'b0000, 3'd6, 1, 1, 0);
    cycle(1, 0, 4'b0000, 3'd0, 1, 1, 0);

    // Backpressure with changing inputs, then handoff plus capture together.
    cycle(1, 1, 4'b0010, 3'd3, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 1, 4'(1 << (i % 3)), 3'd6, 0, 0, 0);
    cycle(1, 1, 4'b0001, 3'd0, 1, 0, 0);
    cycle(1, 0, 4'b0000, 3'd0, 1, 0, 0);

    // Saturation of the narrow counter, then clear alongside a true handoff.
    cycle(1, 0, 4'b0000, 3'd0, 1, 0, 1);
    for (int i = 0; i < 5; i++) cycle(1, 1, 4'b0001, 3'd6, 1, 0, 0);
    cycle(1, 1, 4'b0001, 3'd6, 1, 0, 1);
    check("cnt_clr_priority", match_cnt2, 0);

    // Reset while FULL and stalled: result discarded, no increment.
    cycle(1, 1, 4'b0100, 3'd6, 0, 0, 0);
    cycle(0, 0, 4'b0000, 3'd0, 1, 0, 0);
    cycle(1, 0, 4'b0000, 3'd0, 1, 0, 0);

    // Random traffic including illegal words, clears and occasional reset.
    for (int i = 0; i < 2500; i++) begin
      fl = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 2));
      cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), fl,
            3'($urandom), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) == 0));
    end

    // Long true stream so the wide counter reaches its saturation value.
    for (int i = 0; i < 300; i++)
      cycle(1, 1, 4'(1 << $urandom_range(0, 2)), 3'd6, 1, 0, 0);
    check("cnt8_saturated", match_cnt, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
